// File: rtl/dot_product_ctrl_p.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_ctrl_p
// Description : Loads vectors A/B element-wise, then runs one MAC per clock to
//               form their dot product. Width, depth and signedness are set by
//               parameters. Vectors are kept after a compute so it can be rerun.
// Revision    : 1.0  initial release
// ============================================================================
module dot_product_ctrl_p #(
  parameter int ELEM_W = 8,
  parameter int DEPTH  = 8,
  parameter int ACC_W  = 20,
  parameter int SIGNED = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic              sel_b_i,
  input  logic [ELEM_W-1:0] wr_data_i,
  input  logic              clr_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic [ACC_W-1:0]  result_o,
  output logic              done_o,
  output logic              full_a_o,
  output logic              full_b_o,
  output logic              err_o
);

  localparam int PTR_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PROD_W = 2 * ELEM_W;

  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MAC  = 1'b1;

  logic [0:0]        state_q,  state_d;
  logic [PTR_W-1:0]  ptr_a_q,  ptr_a_d;
  logic [PTR_W-1:0]  ptr_b_q,  ptr_b_d;
  logic              full_a_q, full_a_d;
  logic              full_b_q, full_b_d;
  logic [PTR_W-1:0]  idx_q,    idx_d;
  logic [ACC_W-1:0]  acc_q,    acc_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              done_q,   done_d;
  logic              err_q,    err_d;
  logic              busy_q,   busy_d;

  logic [ELEM_W-1:0] mem_a_q [DEPTH];
  logic [ELEM_W-1:0] mem_b_q [DEPTH];

  logic              w_idle;
  logic              w_start_ok;
  logic              w_start_rej;
  logic              w_wr_a;
  logic              w_wr_b;
  logic              w_last;
  logic [ELEM_W-1:0] w_op_a;
  logic [ELEM_W-1:0] w_op_b;
  logic [PROD_W-1:0] w_a_ext;
  logic [PROD_W-1:0] w_b_ext;
  logic [PROD_W-1:0] w_prod;
  logic              w_prod_sign;
  logic [ACC_W-1:0]  w_prod_ext;
  logic [ACC_W-1:0]  w_sum;

  // CLR outranks every other request, so it gates both start and writes.
  assign w_idle      = (state_q == S_IDLE);
  assign w_start_ok  = w_idle & start_i & full_a_q & full_b_q & ~clr_i;
  assign w_start_rej = w_idle & start_i & ~(full_a_q & full_b_q) & ~clr_i;
  assign w_wr_a      = w_idle & wr_en_i & ~sel_b_i & ~full_a_q & ~clr_i & ~w_start_ok;
  assign w_wr_b      = w_idle & wr_en_i &  sel_b_i & ~full_b_q & ~clr_i & ~w_start_ok;
  assign w_last      = (state_q == S_MAC) & (idx_q == LAST_IDX);

  assign w_op_a = mem_a_q[idx_q[IDX_W-1:0]];
  assign w_op_b = mem_b_q[idx_q[IDX_W-1:0]];

  // Operands are widened first so a plain modular multiply yields the
  // correct two's-complement product in the signed case.
  generate
    if (SIGNED != 0) begin : g_signed
      assign w_a_ext     = {{ELEM_W{w_op_a[ELEM_W-1]}}, w_op_a};
      assign w_b_ext     = {{ELEM_W{w_op_b[ELEM_W-1]}}, w_op_b};
      assign w_prod_sign = w_prod[PROD_W-1];
    end else begin : g_unsigned
      assign w_a_ext     = {{ELEM_W{1'b0}}, w_op_a};
      assign w_b_ext     = {{ELEM_W{1'b0}}, w_op_b};
      assign w_prod_sign = 1'b0;
    end
  endgenerate

  assign w_prod = w_a_ext * w_b_ext;

  generate
    if (ACC_W > PROD_W) begin : g_ext_wide
      assign w_prod_ext = {{(ACC_W - PROD_W){w_prod_sign}}, w_prod};
    end else begin : g_ext_narrow
      assign w_prod_ext = w_prod[ACC_W-1:0];
    end
  endgenerate

  assign w_sum = acc_q + w_prod_ext;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (w_start_ok) state_d = S_MAC;
        S_MAC:   if (w_last)     state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d   = (state_d == S_MAC);
    err_d    = w_start_rej;
    done_d   = done_q;
    result_d = result_q;
    if (clr_i) begin
      done_d   = 1'b0;
      result_d = '0;
    end else if (w_start_ok) begin
      done_d   = 1'b0;
    end else if (w_last) begin
      done_d   = 1'b1;
      result_d = w_sum;
    end
  end

  always_comb begin
    ptr_a_d  = ptr_a_q + PTR_W'(w_wr_a);
    ptr_b_d  = ptr_b_q + PTR_W'(w_wr_b);
    idx_d    = idx_q;
    acc_d    = acc_q;
    if (clr_i) begin
      ptr_a_d = '0;
      ptr_b_d = '0;
      idx_d   = '0;
      acc_d   = '0;
    end else if (w_start_ok) begin
      idx_d   = '0;
      acc_d   = '0;
    end else if (state_q == S_MAC) begin
      acc_d   = w_sum;
      idx_d   = w_last ? '0 : idx_q + 1'b1;
    end
    full_a_d = (ptr_a_d == PTR_FULL);
    full_b_d = (ptr_b_d == PTR_FULL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_a_q  <= '0;
      ptr_b_q  <= '0;
      full_a_q <= 1'b0;
      full_b_q <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ptr_a_q  <= ptr_a_d;
      ptr_b_q  <= ptr_b_d;
      full_a_q <= full_a_d;
      full_b_q <= full_b_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  // Element storage carries no reset; its contents are only read once full.
  always_ff @(posedge clk_i) begin
    if (w_wr_a) mem_a_q[ptr_a_q[IDX_W-1:0]] <= wr_data_i;
    if (w_wr_b) mem_b_q[ptr_b_q[IDX_W-1:0]] <= wr_data_i;
  end

  assign busy_o   = busy_q;
  assign result_o = result_q;
  assign done_o   = done_q;
  assign full_a_o = full_a_q;
  assign full_b_o = full_b_q;
  assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dot_product_ctrl_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_product_ctrl_p
// Description : Bench driving three configurations (unsigned D4, signed D4,
//               unsigned D8 wrapping) from shared control lines.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dot_product_ctrl_p;

  logic clk = 1'b0;
  logic rst_n, wr_en, sel_b, clr, start;
  logic [7:0] wd_u, wd_s, wd_m;

  logic        busy_u, done_u, fa_u, fb_u, err_u;
  logic        busy_s, done_s, fa_s, fb_s, err_s;
  logic        busy_m, done_m, fa_m, fb_m, err_m;
  logic [17:0] res_u, res_s;
  logic [15:0] res_m;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] q_u[$];
  logic [31:0] q_s[$];
  logic [31:0] q_m[$];

  logic [7:0] a_u [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd9, 8'd9, 8'd9};
  logic [7:0] b_u [8] = '{8'd5, 8'd6, 8'd7, 8'd8, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
  logic [7:0] a_s [8] = '{8'hFF, 8'd2, 8'h80, 8'd0, 8'h55, 8'h55, 8'h55, 8'h55};
  logic [7:0] b_s [8] = '{8'd3, 8'hFE, 8'd1, 8'd5, 8'h66, 8'h66, 8'h66, 8'h66};

  always #5 clk = ~clk;

  dot_product_ctrl_p #(.ELEM_W(8), .DEPTH(4), .ACC_W(18), .SIGNED(0)) u_dut_u (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .sel_b_i(sel_b), .wr_data_i(wd_u),
    .clr_i(clr), .start_i(start), .busy_o(busy_u), .result_o(res_u), .done_o(done_u),
    .full_a_o(fa_u), .full_b_o(fb_u), .err_o(err_u));

  dot_product_ctrl_p #(.ELEM_W(8), .DEPTH(4), .ACC_W(18), .SIGNED(1)) u_dut_s (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .sel_b_i(sel_b), .wr_data_i(wd_s),
    .clr_i(clr), .start_i(start), .busy_o(busy_s), .result_o(res_s), .done_o(done_s),
    .full_a_o(fa_s), .full_b_o(fb_s), .err_o(err_s));

  dot_product_ctrl_p #(.ELEM_W(8), .DEPTH(8), .ACC_W(16), .SIGNED(0)) u_dut_m (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .sel_b_i(sel_b), .wr_data_i(wd_m),
    .clr_i(clr), .start_i(start), .busy_o(busy_m), .result_o(res_m), .done_o(done_m),
    .full_a_o(fa_m), .full_b_o(fb_m), .err_o(err_m));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic vb, input logic [7:0] du, input logic [7:0] ds, input logic [7:0] dm);
    wr_en = 1'b1; sel_b = vb; wd_u = du; wd_s = ds; wd_m = dm;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < 8; i++) wr(1'b0, a_u[i], a_s[i], 8'hFF);
    for (int i = 0; i < 8; i++) wr(1'b1, b_u[i], b_s[i], 8'hFF);
  endtask

  // Pushes the expected sums at START, pops them as each DONE appears.
  task automatic run_compute(input string tag);
    int  nb_u, nb_m;
    bit  got_u, got_s, got_m;
    nb_u = 0; nb_m = 0; got_u = 0; got_s = 0; got_m = 0;
    q_u.push_back(32'd70);
    q_s.push_back(32'h3FF79);
    q_m.push_back(32'hF008);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_done_cleared"}, 32'(done_u), 32'd0);
    for (int c = 0; c < 16 && !(got_u && got_s && got_m); c++) begin
      if (busy_u) nb_u++;
      if (busy_m) nb_m++;
      if (done_u && !got_u) begin
        got_u = 1;
        chk({tag, "_u_latency"}, 32'(c), 32'd4);
        chk({tag, "_u_result"}, 32'(res_u), q_u.pop_front());
      end
      if (done_s && !got_s) begin
        got_s = 1;
        chk({tag, "_s_result"}, 32'(res_s), q_s.pop_front());
      end
      if (done_m && !got_m) begin
        got_m = 1;
        chk({tag, "_m_latency"}, 32'(c), 32'd8);
        chk({tag, "_m_result"}, 32'(res_m), q_m.pop_front());
      end
      tick();
    end
    chk({tag, "_u_seen"}, 32'(got_u), 32'd1);
    chk({tag, "_s_seen"}, 32'(got_s), 32'd1);
    chk({tag, "_m_seen"}, 32'(got_m), 32'd1);
    chk({tag, "_u_busy_cycles"}, 32'(nb_u), 32'd4);
    chk({tag, "_m_busy_cycles"}, 32'(nb_m), 32'd8);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; sel_b = 1'b0; clr = 1'b0; start = 1'b0;
    wd_u = '0; wd_s = '0; wd_m = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   32'(busy_u | busy_s | busy_m), 32'd0);
    chk("rst_done",   32'(done_u | done_s | done_m), 32'd0);
    chk("rst_result", 32'(res_u | res_s | 18'(res_m)), 32'd0);
    chk("rst_full",   32'(fa_u | fb_u | fa_m | fb_m), 32'd0);
    chk("rst_err",    32'(err_u | err_s | err_m), 32'd0);
    rst_n = 1'b1;
    tick();

    // Eight A writes: the D4 units see four overflow writes that must be ignored.
    for (int i = 0; i < 8; i++) begin
      wr(1'b0, a_u[i], a_s[i], 8'hFF);
      if (i == 3) begin
        chk("fa_u_after4", 32'(fa_u), 32'd1);
        chk("fa_m_after4", 32'(fa_m), 32'd0);
      end
    end
    chk("fa_m_after8", 32'(fa_m), 32'd1);
    chk("fb_u_empty",  32'(fb_u), 32'd0);

    for (int i = 0; i < 3; i++) wr(1'b1, b_u[i], b_s[i], 8'hFF);
    chk("fb_u_after3", 32'(fb_u), 32'd0);

    start = 1'b1; wr_en = 1'b1; sel_b = 1'b1; wd_u = b_u[3]; wd_s = b_s[3]; wd_m = 8'hFF;
    tick();
    start = 1'b0; wr_en = 1'b0;
    chk("err_u_pulse", 32'(err_u), 32'd1);
    chk("err_s_pulse", 32'(err_s), 32'd1);
    chk("err_m_pulse", 32'(err_m), 32'd1);
    chk("rej_busy",    32'(busy_u), 32'd0);
    chk("rej_wr_fb_u", 32'(fb_u), 32'd1);
    chk("rej_fb_m",    32'(fb_m), 32'd0);
    tick();
    chk("err_u_one_cycle", 32'(err_u), 32'd0);

    for (int i = 4; i < 8; i++) wr(1'b1, b_u[i], b_s[i], 8'hFF);
    chk("fb_m_after8", 32'(fb_m), 32'd1);

    run_compute("c1");
    chk("c1_done_hold", 32'(done_u), 32'd1);
    run_compute("c2_recompute");

    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_clr_busy",   32'(busy_u), 32'd1);
    chk("pre_clr_result", 32'(res_u), 32'd70);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy_u",   32'(busy_u), 32'd0);
    chk("clr_busy_m",   32'(busy_m), 32'd0);
    chk("clr_done",     32'(done_u | done_m), 32'd0);
    chk("clr_result_u", 32'(res_u), 32'd0);
    chk("clr_result_m", 32'(res_m), 32'd0);
    chk("clr_full",     32'(fa_u | fb_u | fa_m | fb_m), 32'd0);
    tick();
    chk("clr_stays_idle", 32'(busy_u | busy_m), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr_start_rej_err",  32'(err_u), 32'd1);
    chk("clr_start_rej_busy", 32'(busy_u), 32'd0);

    fill_all();
    run_compute("c3_refill");

    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_busy",   32'(busy_u), 32'd1);
    chk("pre_rst_result", 32'(res_u), 32'd70);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",   32'(busy_u | busy_s | busy_m), 32'd0);
    chk("arst_result", 32'(res_u), 32'd0);
    chk("arst_full",   32'(fa_u | fb_u | fa_m | fb_m), 32'd0);
    chk("arst_done",   32'(done_u | done_m), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy_u | busy_m), 32'd0);

    chk("sb_empty", 32'(q_u.size() + q_s.size() + q_m.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/dot_product_ctrl_p.md
Name: dot_product_ctrl_p

Overview:
- Parametrised successor to the two-vector dot-product controller.
- Loads vectors A and B element-by-element into internal register files, then runs one multiply-accumulate (MAC) per clock to produce their dot product.
- Adds configurable width, depth and signedness, a clear/abort input, an error flag, and the ability to recompute on retained vectors.
- Sits between the keypad/input path and the result display logic.

Parameters:
- ELEM_W, 8: element width in bits.
- DEPTH, 8: elements per vector; must be at least 2.
- ACC_W, 20: accumulator and result width; must be at least 2*ELEM_W.
- SIGNED, 0: 0 means unsigned operands; 1 means two's-complement operands and result.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- WR_EN  in  1  write strobe for one element.
- SEL_B  in  1  target vector for the write: 0 = A, 1 = B.
- WR_DATA  in  ELEM_W  element value to write.
- CLR  in  1  synchronous clear/abort.
- START  in  1  compute request.
- BUSY  out  1  high while MAC is in progress.
- RESULT  out  ACC_W  last completed dot product.
- DONE  out  1  RESULT is valid.
- FULL_A  out  1  vector A holds DEPTH elements.
- FULL_B  out  1  vector B holds DEPTH elements.
- ERR  out  1  one-cycle pulse when START is rejected.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE; both write pointers=0; accumulator=0.
  - RESULT=0, DONE=0, BUSY=0, FULL_A=0, FULL_B=0, ERR=0.
  - Element storage contents are don't-care.
- States: IDLE and MAC. BUSY = (state==MAC).
- Writes (IDLE only):
  - WR_EN=1 stores WR_DATA at ptr_A or ptr_B, selected by SEL_B, then increments that pointer.
  - FULL_x is set when ptr_x reaches DEPTH.
  - Writes to a full vector are ignored: no wrap, no overwrite.
  - WR_EN is ignored in MAC.
- START in IDLE with FULL_A=1 and FULL_B=1 (edge k):
  - Index i=0, accumulator=0, state goes to MAC; DONE cleared.
  - A WR_EN in the same cycle is dropped.
- START in IDLE with either vector not full:
  - ERR pulses high for exactly one cycle; state stays IDLE.
  - A WR_EN in the same cycle is accepted normally.
  - DONE and RESULT are unchanged.
- START in MAC is ignored.
- MAC:
  - Each cycle: acc <= acc + A[i]*B[i]; i <= i+1.
  - The product is 2*ELEM_W wide, sign- or zero-extended to ACC_W according to SIGNED.
  - The sum wraps modulo 2^ACC_W; there is no saturation.
- Completion:
  - On the edge that performs the final accumulation (i=DEPTH-1, edge k+DEPTH), RESULT takes the final sum, DONE goes to 1, and state returns to IDLE.
  - BUSY is high for exactly DEPTH cycles.
- DONE stays high until the next accepted START, CLR, or reset.
- Vectors are retained after compute. A new START with no writes recomputes the identical result.
- CLR (synchronous, highest priority, any state):
  - state=IDLE; pointers=0; FULL_A=0, FULL_B=0; DONE=0; RESULT=0; accumulator=0.
  - Aborts an in-flight MAC.
  - CLR in the same cycle as START or WR_EN wins; the other request is dropped.
- Reset asserted mid-MAC returns everything to reset values immediately, without waiting for a clock edge.
- ptr and i widths are clog2(DEPTH+1). All outputs are registered.

Test Plan:
- Unsigned compute (DEPTH=4, ELEM_W=8, ACC_W=18):
  - Stimulus: write A=1,2,3,4 and B=5,6,7,8, then START.
  - Response: BUSY high 4 cycles; on edge k+4, RESULT=70 and DONE=1; START again with no writes gives RESULT=70.
- Signed compute (SIGNED=1):
  - Stimulus: A=0xFF,2,0x80,0; B=3,0xFE,1,5.
  - Response: RESULT = -3 - 4 - 128 = -135 (0x3FF79 at ACC_W=18).
- Maximum operands, unsigned (DEPTH=8, ACC_W=16):
  - Stimulus: all elements 0xFF.
  - Response: RESULT = 8*65025 mod 65536 = 0xF008 (wraps, no saturation).
- START with an incomplete vector and a write in the same cycle:
  - Stimulus: A full, B holding 3 of 4 elements; START with WR_EN=1, SEL_B=1.
  - Response: ERR pulses for 1 cycle; FULL_B=1 on the next edge; the following START is accepted.
- Overflow writes:
  - Stimulus: a 5th write to A with DEPTH=4.
  - Response: ignored; A[0..3] unchanged, verified by recompute.
- CLR and reset mid-MAC:
  - CLR at MAC cycle 2: BUSY=0 next edge; DONE=0, RESULT=0, FULL_A=FULL_B=0.
  - RST_N low mid-MAC: all outputs 0 asynchronously, before the next clock edge.
